uart_tx_serializer: RTL and testbench

- Transmit serializer that sits directly downstream of the team's bit-period divider.
- Consumes the divider's one-cycle `at_max` tick as `baud_tick` and drives the divider's `enable`/`clear` inputs.
- Converts a parallel byte from the game-logic side into an asynchronous serial frame for the wireless module: start bit, LSB-first data, optional even parity, stop bits.

---
 rtl/uart_pkg.sv | 15 +
 rtl/uart_tx_serializer.sv | 113 +++++++++++
 tb/tb_uart_tx_serializer.sv | 307 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: transmit FSM states and serial line levels.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } tx_state_t;

  localparam logic IDLE_LEVEL  = 1'b1;
  localparam logic START_LEVEL = 1'b0;

endpackage

// File: rtl/uart_tx_serializer.sv
// Frame serializer paced by the divider's baud_tick. tx_serial follows accept by 1 cycle.
// Each bit lasts max+1 cycles. Holds tx_ready low for the whole frame; tx_valid is ignored while busy.
module uart_tx_serializer
  import uart_pkg::*;
#(
  parameter int DATA_BITS = 8,
  parameter int PARITY_EN = 0,
  parameter int STOP_BITS = 1
) (
  input  logic                 clk,
  input  logic                 Rst,
  input  logic                 baud_tick,
  input  logic                 tx_valid,
  input  logic [DATA_BITS-1:0] tx_data,
  output logic                 tx_ready,
  output logic                 div_enable,
  output logic                 div_clear,
  output logic                 tx_serial,
  output logic                 busy,
  output logic                 frame_done
);

  localparam int              CNT_W    = $clog2(DATA_BITS + 1);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_BITS - 1);
  localparam logic            LAST_STOP = 1'(STOP_BITS - 1);

  tx_state_t              state;
  logic [DATA_BITS-1:0]   shift_reg;
  logic [CNT_W-1:0]       bit_cnt;
  logic                   parity;
  logic                   stop_cnt;

  always_ff @(posedge clk or posedge Rst) begin
    if (Rst) begin
      state      <= IDLE;
      shift_reg  <= '0;
      bit_cnt    <= '0;
      parity     <= 1'b0;
      stop_cnt   <= 1'b0;
      tx_serial  <= IDLE_LEVEL;
      tx_ready   <= 1'b1;
      busy       <= 1'b0;
      frame_done <= 1'b0;
      div_enable <= 1'b0;
      div_clear  <= 1'b1;
    end else begin
      frame_done <= 1'b0;
      case (state)
        IDLE: begin
          if (tx_valid && tx_ready) begin
            shift_reg  <= tx_data;
            parity     <= 1'b0;
            bit_cnt    <= '0;
            stop_cnt   <= 1'b0;
            state      <= START;
            tx_serial  <= START_LEVEL;
            tx_ready   <= 1'b0;
            busy       <= 1'b1;
            div_enable <= 1'b1;
            div_clear  <= 1'b0;
          end
        end
        START: begin
          if (baud_tick) begin
            state     <= DATA;
            tx_serial <= shift_reg[0];
          end
        end
        DATA: begin
          if (baud_tick) begin
            shift_reg <= shift_reg >> 1;
            parity    <= parity ^ shift_reg[0];
            bit_cnt   <= bit_cnt + 1'b1;
            if (bit_cnt == LAST_BIT) begin
              // Parity must include the bit leaving on this same tick.
              if (PARITY_EN != 0) begin
                state     <= PARITY;
                tx_serial <= parity ^ shift_reg[0];
              end else begin
                state     <= STOP;
                tx_serial <= IDLE_LEVEL;
              end
            end else begin
              tx_serial <= shift_reg[1];
            end
          end
        end
        PARITY: begin
          if (baud_tick) begin
            state     <= STOP;
            tx_serial <= IDLE_LEVEL;
          end
        end
        STOP: begin
          if (baud_tick) begin
            if (stop_cnt == LAST_STOP) begin
              state      <= IDLE;
              frame_done <= 1'b1;
              tx_ready   <= 1'b1;
              busy       <= 1'b0;
              div_enable <= 1'b0;
              div_clear  <= 1'b1;
            end else begin
              stop_cnt <= 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_serializer.sv
// Bench: four serializer configurations, each paced by a local divider model and checked per cycle.
module tb_uart_tx_serializer;

  typedef struct packed {
    logic ser;
    logic busy;
    logic rdy;
    logic fd;
  } exp_t;

  localparam exp_t IDLE_E = 4'b1010;
  localparam exp_t DONE_E = 4'b1011;

  logic       clk = 1'b0;
  logic       Rst;
  logic [3:0] baud_tick, tx_valid, tx_ready, div_enable, div_clear, tx_serial, busy, frame_done;
  logic [7:0] tx_data [4];

  int maxv [4];
  int dcnt [4];
  int acc_cnt [4];
  int fd_at [4];
  int db  [4] = '{8, 8, 8, 5};
  int pen [4] = '{0, 1, 0, 1};
  int sb  [4] = '{1, 1, 2, 2};

  exp_t exp_q [4][$];
  exp_t cur [4];
  bit   cap [4][$];
  bit   fbits[$];

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  uart_tx_serializer #(.DATA_BITS(8), .PARITY_EN(0), .STOP_BITS(1)) u0 (
    .clk(clk), .Rst(Rst), .baud_tick(baud_tick[0]), .tx_valid(tx_valid[0]), .tx_data(tx_data[0]),
    .tx_ready(tx_ready[0]), .div_enable(div_enable[0]), .div_clear(div_clear[0]),
    .tx_serial(tx_serial[0]), .busy(busy[0]), .frame_done(frame_done[0]));
  uart_tx_serializer #(.DATA_BITS(8), .PARITY_EN(1), .STOP_BITS(1)) u1 (
    .clk(clk), .Rst(Rst), .baud_tick(baud_tick[1]), .tx_valid(tx_valid[1]), .tx_data(tx_data[1]),
    .tx_ready(tx_ready[1]), .div_enable(div_enable[1]), .div_clear(div_clear[1]),
    .tx_serial(tx_serial[1]), .busy(busy[1]), .frame_done(frame_done[1]));
  uart_tx_serializer #(.DATA_BITS(8), .PARITY_EN(0), .STOP_BITS(2)) u2 (
    .clk(clk), .Rst(Rst), .baud_tick(baud_tick[2]), .tx_valid(tx_valid[2]), .tx_data(tx_data[2]),
    .tx_ready(tx_ready[2]), .div_enable(div_enable[2]), .div_clear(div_clear[2]),
    .tx_serial(tx_serial[2]), .busy(busy[2]), .frame_done(frame_done[2]));
  uart_tx_serializer #(.DATA_BITS(5), .PARITY_EN(1), .STOP_BITS(2)) u3 (
    .clk(clk), .Rst(Rst), .baud_tick(baud_tick[3]), .tx_valid(tx_valid[3]), .tx_data(tx_data[3][4:0]),
    .tx_ready(tx_ready[3]), .div_enable(div_enable[3]), .div_clear(div_clear[3]),
    .tx_serial(tx_serial[3]), .busy(busy[3]), .frame_done(frame_done[3]));

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d t=%0t", nm, act, exp, $time);
    end
  endtask

  // Bit-level frame image: start, LSB-first data, optional even parity, stop bits.
  function automatic void frame_bits(input int i, input logic [7:0] d);
    bit par;
    par = 1'b0;
    fbits.delete();
    fbits.push_back(1'b0);
    for (int k = 0; k < db[i]; k++) begin
      fbits.push_back(d[k]);
      par ^= d[k];
    end
    if (pen[i] != 0) fbits.push_back(par);
    for (int s = 0; s < sb[i]; s++) fbits.push_back(1'b1);
  endfunction

  function automatic void build(input int i, input logic [7:0] d, input int mx);
    frame_bits(i, d);
    foreach (fbits[k])
      for (int r = 0; r <= mx; r++) exp_q[i].push_back(exp_t'({fbits[k], 3'b100}));
    exp_q[i].push_back(DONE_E);
  endfunction

  // Divider stand-in: free-running count of max+1 cycles while enabled.
  always_comb
    for (int i = 0; i < 4; i++) baud_tick[i] = (dcnt[i] == maxv[i]);

  always @(posedge clk)
    for (int i = 0; i < 4; i++)
      if (div_clear[i]) dcnt[i] <= 0;
      else if (div_enable[i]) dcnt[i] <= (dcnt[i] >= maxv[i]) ? 0 : dcnt[i] + 1;

  always @(posedge clk)
    for (int i = 0; i < 4; i++)
      if (!Rst && cur[i].rdy && tx_valid[i]) begin
        build(i, tx_data[i], maxv[i]);
        acc_cnt[i]++;
      end

  always @(negedge clk)
    for (int i = 0; i < 4; i++) begin
      if (Rst) begin
        exp_q[i].delete();
        cur[i] = IDLE_E;
      end else if (exp_q[i].size() > 0) cur[i] = exp_q[i].pop_front();
      else cur[i] = IDLE_E;
      chk($sformatf("tx_serial[%0d]", i), tx_serial[i], cur[i].ser);
      chk($sformatf("busy[%0d]", i), busy[i], cur[i].busy);
      chk($sformatf("tx_ready[%0d]", i), tx_ready[i], cur[i].rdy);
      chk($sformatf("frame_done[%0d]", i), frame_done[i], cur[i].fd);
      chk($sformatf("div_enable[%0d]", i), div_enable[i], cur[i].busy);
      chk($sformatf("div_clear[%0d]", i), div_clear[i], !cur[i].busy);
      if (busy[i]) cap[i].push_back(tx_serial[i]);
      if (frame_done[i]) fd_at[i] = cap[i].size();
    end

  task automatic send(input int i, input logic [7:0] d);
    int a0;
    int n;
    a0 = acc_cnt[i];
    n = 0;
    tx_data[i]  = d;
    tx_valid[i] = 1'b1;
    while (acc_cnt[i] == a0 && n < 500) begin
      @(posedge clk); #1;
      n++;
    end
    tx_valid[i] = 1'b0;
    tx_data[i]  = 8'($urandom);
    chk("send_accepted", acc_cnt[i] - a0, 1);
  endtask

  task automatic wait_idle(input int i);
    int n;
    n = 0;
    while (!(exp_q[i].size() == 0 && cur[i].rdy) && n < 2000) begin
      @(posedge clk); #1;
      n++;
    end
    chk("idle_reached", int'(n < 2000), 1);
  endtask

  task automatic start_cap(input int i);
    cap[i].delete();
    fd_at[i] = -1;
  endtask

  task automatic check_frame(input int i, input logic [7:0] d, input int mx);
    frame_bits(i, d);
    chk("cap_len", cap[i].size(), fbits.size() * (mx + 1));
    chk("done_at", fd_at[i], fbits.size() * (mx + 1));
    foreach (fbits[k])
      if (k * (mx + 1) < cap[i].size()) chk($sformatf("bit%0d", k), cap[i][k * (mx + 1)], fbits[k]);
  endtask

  initial begin
    int a5_exp [10] = '{0, 1, 0, 1, 0, 0, 1, 0, 1, 1};
    int f_exp  [10] = '{0, 1, 1, 1, 1, 0, 0, 0, 0, 1};
    bit   both[$];
    logic [7:0] d;
    int   a0;
    int   n;
    int   i;

    Rst = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tx_valid[k] = 1'b0;
      tx_data[k]  = 8'h00;
      maxv[k] = 0;
      dcnt[k] = 0;
      acc_cnt[k] = 0;
      fd_at[k] = -1;
      cur[k] = IDLE_E;
    end
    repeat (3) @(posedge clk);
    #1;
    for (int k = 0; k < 4; k++) begin
      chk("rst_serial", tx_serial[k], 1);
      chk("rst_ready", tx_ready[k], 1);
      chk("rst_busy", busy[k], 0);
      chk("rst_done", frame_done[k], 0);
      chk("rst_en", div_enable[k], 0);
      chk("rst_clr", div_clear[k], 1);
    end
    Rst = 1'b0;
    @(posedge clk); #1;

    // Pin the model against hand-derived frames.
    frame_bits(0, 8'hA5);
    chk("model_len_a5", fbits.size(), 10);
    for (int k = 0; k < 10; k++) chk("model_a5", fbits[k], a5_exp[k]);
    frame_bits(1, 8'h07);
    chk("model_par07", fbits[9], 1);
    chk("model_len_par", fbits.size(), 11);

    // A5 with max=3: every level held 4 cycles, frame_done 40 cycles after start.
    maxv[0] = 3;
    start_cap(0);
    send(0, 8'hA5);
    wait_idle(0);
    chk("a5_len", cap[0].size(), 40);
    chk("a5_done_at", fd_at[0], 40);
    for (int k = 0; k < 40; k++) if (k < cap[0].size()) chk("a5_level", cap[0][k], a5_exp[k / 4]);

    // Even parity.
    maxv[1] = 3;
    start_cap(1);
    send(1, 8'h07);
    wait_idle(1);
    chk("par07_len", cap[1].size(), 44);
    if (cap[1].size() > 36) chk("par07_bit", cap[1][36], 1);
    start_cap(1);
    send(1, 8'h03);
    wait_idle(1);
    if (cap[1].size() > 36) chk("par03_bit", cap[1][36], 0);
    check_frame(1, 8'h03, 3);

    // Back-to-back frames with max=0 and tx_valid held.
    maxv[0] = 0;
    start_cap(0);
    a0 = acc_cnt[0];
    tx_data[0]  = 8'h55;
    tx_valid[0] = 1'b1;
    n = 0;
    while (acc_cnt[0] == a0 && n < 100) begin @(posedge clk); #1; n++; end
    tx_data[0] = 8'hAA;
    n = 0;
    while (acc_cnt[0] < a0 + 2 && n < 100) begin @(posedge clk); #1; n++; end
    tx_valid[0] = 1'b0;
    wait_idle(0);
    chk("b2b_accepts", acc_cnt[0] - a0, 2);
    frame_bits(0, 8'h55);
    both = fbits;
    frame_bits(0, 8'hAA);
    both = {both, fbits};
    chk("b2b_len", cap[0].size(), 20);
    foreach (both[k]) if (k < cap[0].size()) chk("b2b_bit", cap[0][k], both[k]);

    // Reset during data bit 3, then a clean 0F frame.
    maxv[0] = 3;
    send(0, 8'hA5);
    repeat (17) @(posedge clk);
    #1;
    chk("busy_before_rst", busy[0], 1);
    Rst = 1'b1;
    #1;
    chk("arst_serial", tx_serial[0], 1);
    chk("arst_busy", busy[0], 0);
    chk("arst_ready", tx_ready[0], 1);
    repeat (2) @(posedge clk);
    #1;
    Rst = 1'b0;
    @(posedge clk); #1;
    start_cap(0);
    send(0, 8'h0F);
    wait_idle(0);
    check_frame(0, 8'h0F, 3);
    for (int k = 0; k < 10; k++) if (4 * k < cap[0].size()) chk("f0_lit", cap[0][4 * k], f_exp[k]);

    // Two stop bits, max=1: stop level high 4 cycles before frame_done.
    maxv[2] = 1;
    start_cap(2);
    send(2, 8'hFF);
    wait_idle(2);
    chk("stop2_done_at", fd_at[2], 22);
    for (int k = 18; k < 22; k++) if (k < cap[2].size()) chk("stop2_level", cap[2][k], 1);
    chk("stop2_start", cap[2].size() > 0 ? int'(cap[2][0]) : 1, 0);

    // Data change and valid pulse mid-frame are ignored.
    d = 8'($urandom);
    start_cap(1);
    a0 = acc_cnt[1];
    send(1, d);
    repeat (10) @(posedge clk);
    #1;
    tx_data[1]  = ~d;
    tx_valid[1] = 1'b1;
    @(posedge clk); #1;
    tx_valid[1] = 1'b0;
    wait_idle(1);
    chk("midframe_accepts", acc_cnt[1] - a0, 1);
    check_frame(1, d, 3);

    // Randomized frames across all configurations.
    for (int it = 0; it < 40; it++) begin
      i = $urandom_range(0, 3);
      maxv[i] = $urandom_range(0, 3);
      start_cap(i);
      d = 8'($urandom);
      send(i, d);
      if ($urandom_range(0, 1) == 1) begin
        repeat ($urandom_range(1, 6)) @(posedge clk);
        #1;
        tx_data[i] = 8'($urandom);
      end
      wait_idle(i);
      check_frame(i, d, maxv[i]);
      repeat ($urandom_range(0, 3)) @(posedge clk);
      #1;
    end

    repeat (3) @(posedge clk);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
